ct_ciu_ncq_wresp_trk: RTL and testbench

- NCQ write-response tracker. Sits directly downstream of the NCQ global (exclusive) monitor, on the waq pop path.
- On each write pop it samples the monitor's exclusive pass/fail result. It forwards the write to the bus only if the write is non-exclusive or a passing exclusive; a failing exclusive is suppressed.
- It queues one response entry per popped write and returns write responses to the requester in pop order. Failing exclusives get a locally generated OKAY; bus-issued writes pass the bus B response through, with EXOKAY substituted for passing exclusives.

---
 rtl/ct_ciu_ncq_pkg.sv | 15 +
 rtl/ct_ciu_ncq_wresp_trk_if.sv | 26 ++
 rtl/ct_ciu_ncq_wresp_fifo.sv | 37 +++
 rtl/ct_ciu_ncq_wresp_trk.sv | 52 +++++
 tb/tb_ct_ciu_ncq_wresp_trk.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ct_ciu_ncq_pkg.sv
// ct_ciu_ncq_pkg: response-kind and BRESP encodings shared by the NCQ write-response path
package ct_ciu_ncq_pkg;
    typedef enum logic [1:0] {
        KIND_LOCAL = 2'd0,
        KIND_BUS   = 2'd1,
        KIND_BUSEX = 2'd2
    } wkind_e;
    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;
    function automatic logic [1:0] ex_resp(input logic [1:0] r);
        return (r == BRESP_OKAY) ? BRESP_EXOKAY : r;
    endfunction
endpackage

// File: rtl/ct_ciu_ncq_wresp_trk_if.sv
// ct_ciu_ncq_wresp_trk_if: waq pop, bus B and requester B channels of the write-response tracker
interface ct_ciu_ncq_wresp_trk_if #(parameter int IDW = 8) ();
    logic           waq_pop_en;
    logic           waq_pop_lock;
    logic [IDW-1:0] waq_pop_id;
    logic           gm_success_x;
    logic           aw_issue_vld;
    logic           aw_drop_vld;
    logic           wtrk_full;
    logic           wtrk_ovf_err;
    logic           bus_b_vld;
    logic [1:0]     bus_b_resp;
    logic           bus_b_ready;
    logic           ncq_b_vld;
    logic [1:0]     ncq_b_resp;
    logic [IDW-1:0] ncq_b_id;
    logic           ncq_b_ready;
    modport slave (
        input  waq_pop_en, waq_pop_lock, waq_pop_id, gm_success_x, bus_b_vld, bus_b_resp, ncq_b_ready,
        output aw_issue_vld, aw_drop_vld, wtrk_full, wtrk_ovf_err, bus_b_ready, ncq_b_vld, ncq_b_resp, ncq_b_id
    );
    modport master (
        output waq_pop_en, waq_pop_lock, waq_pop_id, gm_success_x, bus_b_vld, bus_b_resp, ncq_b_ready,
        input  aw_issue_vld, aw_drop_vld, wtrk_full, wtrk_ovf_err, bus_b_ready, ncq_b_vld, ncq_b_resp, ncq_b_id
    );
endinterface

// File: rtl/ct_ciu_ncq_wresp_fifo.sv
// ct_ciu_ncq_wresp_fifo: in-order response-entry queue with registered occupancy count
module ct_ciu_ncq_wresp_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 10,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic         forever_cpuclk,
    input  logic         cpurst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]    mem [DEPTH];
    logic [PTRW-1:0] wptr;
    logic [PTRW-1:0] rptr;
    logic [PTRW:0]   cnt;
    assign full  = cnt == (PTRW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[rptr];
    always_ff @(posedge forever_cpuclk) begin
        if (push) mem[wptr] <= din;
    end
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PTRW'(1);
            if (pop) rptr <= rptr + PTRW'(1);
            if (push != pop) cnt <= push ? cnt + (PTRW+1)'(1) : cnt - (PTRW+1)'(1);
        end
    end
endmodule

// File: rtl/ct_ciu_ncq_wresp_trk.sv
// ct_ciu_ncq_wresp_trk: gates exclusive writes on the monitor result and returns B responses in pop order
module ct_ciu_ncq_wresp_trk
    import ct_ciu_ncq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDW   = 8
) (
    input logic                     forever_cpuclk,
    input logic                     cpurst,
    ct_ciu_ncq_wresp_trk_if.slave   wtrk
);
    logic           fail;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic           ovf;
    logic           head_local;
    wkind_e         push_kind;
    wkind_e         head_kind;
    logic [IDW+1:0] head;
    assign fail      = wtrk.waq_pop_lock & ~wtrk.gm_success_x;
    // reset also masks the pop so nothing issues or queues while cpurst is high
    assign push      = wtrk.waq_pop_en & ~full & ~cpurst;
    assign push_kind = ~wtrk.waq_pop_lock ? KIND_BUS : wtrk.gm_success_x ? KIND_BUSEX : KIND_LOCAL;
    ct_ciu_ncq_wresp_fifo #(.DEPTH(DEPTH), .W(IDW + 2)) u_fifo (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .push           (push),
        .din            ({wtrk.waq_pop_id, push_kind}),
        .pop            (pop),
        .dout           (head),
        .full           (full),
        .empty          (empty)
    );
    assign head_kind         = wkind_e'(head[1:0]);
    assign head_local        = head_kind == KIND_LOCAL;
    assign wtrk.aw_issue_vld = push & ~fail;
    assign wtrk.aw_drop_vld  = push & fail;
    assign wtrk.wtrk_full    = full;
    assign wtrk.wtrk_ovf_err = ovf;
    assign wtrk.ncq_b_vld    = ~empty & (head_local | wtrk.bus_b_vld);
    assign wtrk.bus_b_ready  = ~empty & ~head_local & wtrk.ncq_b_ready;
    assign wtrk.ncq_b_resp   = (empty | head_local) ? BRESP_OKAY :
                               (head_kind == KIND_BUSEX) ? ex_resp(wtrk.bus_b_resp) : wtrk.bus_b_resp;
    assign wtrk.ncq_b_id     = empty ? '0 : head[IDW+1:2];
    assign pop               = wtrk.ncq_b_vld & wtrk.ncq_b_ready;
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) ovf <= 1'b0;
        else if (wtrk.waq_pop_en & full) ovf <= 1'b1;
    end
endmodule

// File: tb/tb_ct_ciu_ncq_wresp_trk.sv
// tb_ct_ciu_ncq_wresp_trk: directed plus random stimulus against a queue-based response scoreboard
module tb_ct_ciu_ncq_wresp_trk;
    import ct_ciu_ncq_pkg::*;
    localparam int DEPTH = 8;
    localparam int IDW   = 8;
    typedef struct {
        logic [IDW-1:0] id;
        int             kind;
    } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ct_ciu_ncq_wresp_trk_if #(.IDW(IDW)) wif ();
    ct_ciu_ncq_wresp_trk #(.DEPTH(DEPTH), .IDW(IDW)) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .wtrk           (wif)
    );
    ent_t sb[$];
    ent_t stage[$];
    int   checks = 0;
    int   errors = 0;
    int   bus_pend = 0;
    int   bus_pct = 50;
    bit   auto_bus = 0;
    bit   bus_taken = 0;
    bit   ovf_hit = 0;
    bit   ovf_m = 0;
    bit   ev;
    bit   er;
    logic [1:0] eresp;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [1:0] pick_resp();
        logic [1:0] rs [4];
        rs = '{BRESP_OKAY, BRESP_EXOKAY, BRESP_SLVERR, BRESP_DECERR};
        return ($urandom_range(1) == 0) ? BRESP_OKAY : rs[$urandom_range(3)];
    endfunction
    task automatic step(input bit pe, input bit lk, input bit gm, input logic [IDW-1:0] id,
                        input bit rdy, input bit bv, input logic [1:0] br);
        @(posedge clk);
        #1;
        wif.waq_pop_en   = pe;
        wif.waq_pop_lock = lk;
        wif.gm_success_x = gm;
        wif.waq_pop_id   = id;
        wif.ncq_b_ready  = rdy;
        if (auto_bus) begin
            if (!(wif.bus_b_vld && !bus_taken)) begin
                wif.bus_b_vld  = (bus_pend > 0) && ($urandom_range(99) < bus_pct);
                wif.bus_b_resp = pick_resp();
            end
        end else begin
            wif.bus_b_vld  = bv;
            wif.bus_b_resp = br;
        end
        ovf_hit = pe && !rst && sb.size() == DEPTH;
        if (pe && !rst && sb.size() < DEPTH) stage.push_back('{id, lk ? (gm ? 2 : 0) : 1});
    endtask
    task automatic idle(input bit rdy);
        step(0, 0, 0, '0, rdy, 0, 2'b00);
    endtask
    task automatic chk_reset_outs(input string tag);
        chk({tag, "_issue"}, wif.aw_issue_vld, 0);
        chk({tag, "_drop"}, wif.aw_drop_vld, 0);
        chk({tag, "_full"}, wif.wtrk_full, 0);
        chk({tag, "_ovf"}, wif.wtrk_ovf_err, 0);
        chk({tag, "_busrdy"}, wif.bus_b_ready, 0);
        chk({tag, "_vld"}, wif.ncq_b_vld, 0);
        chk({tag, "_resp"}, wif.ncq_b_resp, 0);
        chk({tag, "_id"}, wif.ncq_b_id, 0);
    endtask
    // reference model: head of the expected queue decides what the requester must see
    always @(negedge clk) begin
        if (rst) begin
            chk_reset_outs("rst");
            sb.delete();
            stage.delete();
            bus_pend = 0;
            ovf_m = 0;
            ovf_hit = 0;
            bus_taken = 0;
        end else begin
            chk("full", wif.wtrk_full, sb.size() == DEPTH);
            chk("ovf", wif.wtrk_ovf_err, ovf_m);
            chk("issue", wif.aw_issue_vld, stage.size() > 0 && stage[0].kind != 0);
            chk("drop", wif.aw_drop_vld, stage.size() > 0 && stage[0].kind == 0);
            ev = 0;
            er = 0;
            eresp = 2'b00;
            if (sb.size() > 0) begin
                if (sb[0].kind == 0) ev = 1;
                else begin
                    ev = wif.bus_b_vld;
                    er = wif.ncq_b_ready;
                    eresp = (sb[0].kind == 2 && wif.bus_b_resp == 2'b00) ? 2'b01 : wif.bus_b_resp;
                end
                chk("id", wif.ncq_b_id, sb[0].id);
            end
            chk("vld", wif.ncq_b_vld, ev);
            chk("busrdy", wif.bus_b_ready, er);
            if (ev) chk("resp", wif.ncq_b_resp, eresp);
            if (ev && wif.ncq_b_ready) void'(sb.pop_front());
            bus_taken = wif.bus_b_vld && er;
            if (bus_taken) bus_pend--;
            while (stage.size() > 0) begin
                if (stage[0].kind != 0) bus_pend++;
                sb.push_back(stage.pop_front());
            end
            if (ovf_hit) ovf_m = 1;
            ovf_hit = 0;
        end
    end
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1;
        wif.waq_pop_en = 1;
        wif.bus_b_vld = 1;
        #1;
        chk_reset_outs("async");
        repeat (n) @(posedge clk);
        #1;
        wif.waq_pop_en = 0;
        wif.bus_b_vld = 0;
        rst = 0;
    endtask
    initial begin
        wif.waq_pop_en = 0;
        wif.waq_pop_lock = 0;
        wif.gm_success_x = 0;
        wif.waq_pop_id = '0;
        wif.bus_b_vld = 0;
        wif.bus_b_resp = 2'b00;
        wif.ncq_b_ready = 0;
        repeat (2) @(posedge clk);
        do_reset(1);
        step(1, 0, 0, 8'h12, 1, 0, 2'b00);
        #1 chk("t1_issue", wif.aw_issue_vld, 1);
        step(0, 0, 0, '0, 1, 1, 2'b00);
        #1 chk("t1_vld", wif.ncq_b_vld, 1);
        chk("t1_id", wif.ncq_b_id, 8'h12);
        chk("t1_resp", wif.ncq_b_resp, 2'b00);
        idle(1);
        step(1, 1, 1, 8'h05, 1, 0, 2'b00);
        step(0, 0, 0, '0, 1, 1, 2'b00);
        #1 chk("t2_exokay", wif.ncq_b_resp, 2'b01);
        step(1, 1, 1, 8'h05, 1, 0, 2'b00);
        step(0, 0, 0, '0, 1, 1, 2'b10);
        #1 chk("t2_slverr", wif.ncq_b_resp, 2'b10);
        step(1, 1, 0, 8'h07, 1, 0, 2'b00);
        #1 chk("t3_drop", wif.aw_drop_vld, 1);
        chk("t3_noissue", wif.aw_issue_vld, 0);
        chk("t3_nobypass", wif.ncq_b_vld, 0);
        idle(1);
        #1 chk("t3_vld", wif.ncq_b_vld, 1);
        chk("t3_id", wif.ncq_b_id, 8'h07);
        step(1, 0, 0, 8'h01, 1, 0, 2'b00);
        step(1, 1, 0, 8'h02, 1, 0, 2'b00);
        #1 chk("t4_held", wif.ncq_b_vld, 0);
        idle(1);
        #1 chk("t4_held2", wif.ncq_b_vld, 0);
        step(0, 0, 0, '0, 1, 1, 2'b00);
        #1 chk("t4_id1", wif.ncq_b_id, 8'h01);
        idle(1);
        #1 chk("t4_id2", wif.ncq_b_id, 8'h02);
        chk("t4_vld2", wif.ncq_b_vld, 1);
        idle(1);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, IDW'(8'h20 + i), 0, 0, 2'b00);
        step(1, 0, 0, 8'h99, 0, 0, 2'b00);
        #1 chk("t5_full", wif.wtrk_full, 1);
        chk("t5_noissue", wif.aw_issue_vld, 0);
        chk("t5_nodrop", wif.aw_drop_vld, 0);
        step(0, 0, 0, '0, 1, 1, 2'b00);
        #1 chk("t5_ovf", wif.wtrk_ovf_err, 1);
        chk("t5_still_full", wif.wtrk_full, 1);
        idle(0);
        #1 chk("t5_notfull", wif.wtrk_full, 0);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 0, '0, 1, 1, 2'b11);
        idle(1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, IDW'(8'h31 + i), 0, 0, 2'b00);
        idle(0);
        #1 chk("t6_queued", wif.ncq_b_vld, 1);
        do_reset(2);
        idle(1);
        #1 chk("t6_empty", wif.ncq_b_vld, 0);
        chk("t6_notfull", wif.wtrk_full, 0);
        auto_bus = 1;
        for (int p = 0; p < 12; p++) begin
            int pe_pct = $urandom_range(10, 95);
            int rdy_pct = $urandom_range(10, 95);
            bus_pct = $urandom_range(20, 90);
            for (int c = 0; c < 250; c++)
                step($urandom_range(99) < pe_pct, $urandom_range(1), $urandom_range(1),
                     IDW'($urandom), $urandom_range(99) < rdy_pct, 0, 2'b00);
        end
        bus_pct = 100;
        for (int c = 0; c < 200 && (sb.size() > 0 || bus_pend > 0); c++) idle(1);
        #1 chk("drain_done", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
